// File: rtl/spi_reg_master_if.sv
// Host-side request/response bundle for spi_reg_master.
// master = host issuing register frames, slave = the SPI controller serving them.
`timescale 1ns/1ps
interface spi_reg_master_if #(parameter int REG_W = 8);
   logic             start;
   logic [1:0]       op;
   logic [5:0]       addr;
   logic [3:0]       nbeats;
   logic [REG_W-1:0] wr_data;
   logic             wr_ack;
   logic [REG_W-1:0] rd_data;
   logic             rd_vld;
   logic [7:0]       status;
   logic             status_vld;
   logic             busy;
   logic             done;
   logic             err;

   modport master (output start, op, addr, nbeats, wr_data,
                   input  wr_ack, rd_data, rd_vld, status, status_vld, busy, done, err);
   modport slave  (input  start, op, addr, nbeats, wr_data,
                   output wr_ack, rd_data, rd_vld, status, status_vld, busy, done, err);
endinterface

// File: rtl/spi_reg_master.sv
// SPI master for the register-slave protocol (CPOL=0, MSB first, byte lane 0 first).
// Define SPI_REG_MASTER_FASTCMD_EN to enable op=11 fast-command frames; otherwise op=11 is rejected.
`timescale 1ns/1ps
module spi_reg_master #(
   parameter int REG_W    = 8,
   parameter int HALF_DIV = 8,
   parameter int GAP_CYC  = 16
) (
   input  logic             clk,
   input  logic             nrst,
   spi_reg_master_if.slave  host,
   output logic             sclk,
   output logic             mosi,
   output logic             nss,
   input  logic             miso
);
   localparam int NB  = REG_W / 8;
   localparam int CW  = $clog2(GAP_CYC);
   localparam int WBW = $clog2(REG_W + 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(HALF_DIV - 1);
   localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [WBW-1:0] CMD_BITS  = WBW'(8);
   localparam logic [WBW-1:0] WORD_BITS = WBW'(REG_W);

   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WBW-1:0]   wbit_q, wbit_d;
   logic [3:0]       beats_q, beats_d;
   logic             in_cmd_q, in_cmd_d, wr_q, wr_d, rd_q, rd_d;
   logic [REG_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, wdat_q, wdat_d;
   logic             sclk_q, sclk_d, mosi_q, mosi_d, nss_q, nss_d;
   logic             miso_s1_q, miso_s1_d, miso_s2_q, miso_s2_d;
   logic [REG_W-1:0] rd_data_q, rd_data_d;
   logic [7:0]       status_q, status_d;
   logic             rd_vld_q, rd_vld_d, status_vld_q, status_vld_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic             op_legal, tick, rise, fall, seg_last, seg_end;
   logic [7:0]       cmd;
   logic [REG_W-1:0] nxt_word;

   // Words travel lane 0 first, so the shift registers hold the byte-reversed word.
   function automatic logic [REG_W-1:0] bswap(input logic [REG_W-1:0] w);
      logic [REG_W-1:0] r;
      for (int i = 0; i < NB; i++) r[8*(NB-1-i) +: 8] = w[8*i +: 8];
      return r;
   endfunction

`ifdef SPI_REG_MASTER_FASTCMD_EN
   assign op_legal = (host.op != 2'b01);
`else
   assign op_legal = !host.op[0];
`endif

   assign cmd      = {host.op, host.addr};
   assign tick     = (cnt_q == HALF_LAST);
   assign rise     = tick && ((state_q == LEAD) || (state_q == SHIFT && !sclk_q));
   assign fall     = tick && (state_q == SHIFT) && sclk_q;
   assign seg_last = (wbit_q == (in_cmd_q ? CMD_BITS : WORD_BITS) - 1'b1);
   assign seg_end  = (wbit_q == (in_cmd_q ? CMD_BITS : WORD_BITS));

   // Word 0 is taken at the accepting start; later words at the fall that closes the previous word.
   assign host.wr_ack = (state_q == IDLE && host.start && host.op == 2'b10 && host.nbeats != 4'd0) ||
                        (fall && seg_end && !in_cmd_q && wr_q && beats_q != 4'd0);

   always_comb begin
      state_d = state_q;   cnt_d = cnt_q + 1'b1;  wbit_d = wbit_q;  beats_d = beats_q;
      in_cmd_d = in_cmd_q; wr_d = wr_q;           rd_d = rd_q;
      tx_sr_d = tx_sr_q;   rx_sr_d = rx_sr_q;     wdat_d = wdat_q;  nxt_word = '0;
      sclk_d = sclk_q;     mosi_d = mosi_q;       nss_d = nss_q;
      miso_s1_d = miso;    miso_s2_d = miso_s1_q;
      rd_data_d = rd_data_q; status_d = status_q; busy_d = busy_q;
      rd_vld_d = 1'b0; status_vld_d = 1'b0; done_d = 1'b0; err_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (host.start && op_legal) begin
               state_d  = LEAD;  busy_d = 1'b1;  nss_d = 1'b0;  sclk_d = 1'b0;
               wr_d     = (host.op == 2'b10);
               rd_d     = (host.op == 2'b00);
               in_cmd_d = 1'b1;  wbit_d = '0;
               beats_d  = host.op[0] ? 4'd0 : host.nbeats;
               wdat_d   = host.wr_data;
               tx_sr_d  = '0;
               tx_sr_d[REG_W-1 -: 8] = cmd;
               mosi_d   = cmd[7];
            end else if (host.start) begin
               err_d = 1'b1;
            end
         end
         LEAD:  if (tick) begin state_d = SHIFT; cnt_d = '0; end
         SHIFT: if (tick) cnt_d = '0;
         TRAIL: if (tick) begin state_d = GAP; nss_d = 1'b1; mosi_d = 1'b0; cnt_d = '0; end
         GAP:   if (cnt_q == GAP_LAST) begin state_d = IDLE; busy_d = 1'b0; done_d = 1'b0 | 1'b1; end
         default: state_d = IDLE;
      endcase

      if (rise) begin
         sclk_d  = 1'b1;
         rx_sr_d = {rx_sr_q[REG_W-2:0], miso_s2_q};
         wbit_d  = wbit_q + 1'b1;
         if (seg_last && in_cmd_q) begin
            status_d = rx_sr_d[7:0]; status_vld_d = 1'b1;
         end else if (seg_last && rd_q) begin
            rd_data_d = bswap(rx_sr_d); rd_vld_d = 1'b1;
         end
      end

      if (fall) begin
         sclk_d = 1'b0;
         if (!seg_end) begin
            tx_sr_d = tx_sr_q << 1;
            mosi_d  = tx_sr_q[REG_W-2];
         end else if (beats_q == 4'd0) begin
            state_d = TRAIL;
         end else begin
            beats_d  = beats_q - 1'b1;
            in_cmd_d = 1'b0;
            wbit_d   = '0;
            nxt_word = !wr_q ? '0 : (in_cmd_q ? wdat_q : host.wr_data);
            tx_sr_d  = bswap(nxt_word);
            mosi_d   = tx_sr_d[REG_W-1];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;  cnt_q <= '0;  wbit_q <= '0;  beats_q <= '0;
         in_cmd_q <= 1'b0; wr_q <= 1'b0; rd_q <= 1'b0;
         tx_sr_q <= '0;    rx_sr_q <= '0; wdat_q <= '0;
         sclk_q <= 1'b0;   mosi_q <= 1'b0; nss_q <= 1'b1;
         miso_s1_q <= 1'b0; miso_s2_q <= 1'b0;
         rd_data_q <= '0;  status_q <= '0;
         rd_vld_q <= 1'b0; status_vld_q <= 1'b0;
         busy_q <= 1'b0;   done_q <= 1'b0; err_q <= 1'b0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;  wbit_q <= wbit_d;  beats_q <= beats_d;
         in_cmd_q <= in_cmd_d; wr_q <= wr_d;   rd_q <= rd_d;
         tx_sr_q <= tx_sr_d;  rx_sr_q <= rx_sr_d; wdat_q <= wdat_d;
         sclk_q <= sclk_d;    mosi_q <= mosi_d; nss_q <= nss_d;
         miso_s1_q <= miso_s1_d; miso_s2_q <= miso_s2_d;
         rd_data_q <= rd_data_d; status_q <= status_d;
         rd_vld_q <= rd_vld_d; status_vld_q <= status_vld_d;
         busy_q <= busy_d;    done_q <= done_d; err_q <= err_d;
      end
   end

   assign sclk            = sclk_q;
   assign mosi            = mosi_q;
   assign nss             = nss_q;
   assign host.rd_data    = rd_data_q;
   assign host.rd_vld     = rd_vld_q;
   assign host.status     = status_q;
   assign host.status_vld = status_vld_q;
   assign host.busy       = busy_q;
   assign host.done       = done_q;
   assign host.err        = err_q;
endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master (REG_W=16) against a behavioural register slave.
`timescale 1ns/1ps
module tb_spi_reg_master;
   localparam int REG_W = 16, HALF_DIV = 6, GAP_CYC = 12, NB = REG_W / 8;

   logic clk = 1'b0, nrst = 1'b0;
   logic sclk, mosi, nss;
   logic miso = 1'b0;

   spi_reg_master_if #(.REG_W(REG_W)) bus();
   spi_reg_master #(.REG_W(REG_W), .HALF_DIV(HALF_DIV), .GAP_CYC(GAP_CYC)) dut (
      .clk(clk), .nrst(nrst), .host(bus), .sclk(sclk), .mosi(mosi), .nss(nss), .miso(miso));

   always #5 clk = ~clk;

   int n_vec = 0, n_bad = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REG_W-1:0] bswap(input logic [REG_W-1:0] w);
      logic [REG_W-1:0] r;
      for (int i = 0; i < NB; i++) r[8*(NB-1-i) +: 8] = w[8*i +: 8];
      return r;
   endfunction

   // write data source: entry (wr_idx - wbase) is offered, advanced by wr_ack
   logic [REG_W-1:0] wvec [0:3];
   int wr_idx = 0, wbase = 0;
   always @(posedge clk) if (bus.wr_ack) wr_idx <= wr_idx + 1;
   assign bus.wr_data = wvec[2'(wr_idx - wbase)];

   // register slave: samples on sclk rise, drives on fall, auto-increments addr
   logic [REG_W-1:0] regs [0:63];
   logic [REG_W-1:0] s_in = '0, s_out = '0;
   logic [7:0] s_cmd = '0, s_status = 8'h5A;
   logic [5:0] s_addr = '0, s_fast = '0;
   int s_bits = 0;
   logic [7:0] mosi_bytes [$];

   always @(negedge nss) begin
      s_bits = 0; s_out = '0; s_out[REG_W-1 -: 8] = s_status; miso = s_out[REG_W-1];
   end
   always @(posedge sclk) if (nss === 1'b0) begin
      s_in = {s_in[REG_W-2:0], mosi}; s_bits++;
      if (s_bits % 8 == 0) mosi_bytes.push_back(s_in[7:0]);
      if (s_bits == 8) begin
         s_cmd = s_in[7:0]; s_addr = s_in[5:0];
         if (s_in[7:6] == 2'b11) s_fast = s_in[5:0];
      end else if (s_bits > 8 && (s_bits - 8) % REG_W == 0) begin
         if (s_cmd[7:6] == 2'b10) regs[s_addr] = bswap(s_in);
         s_addr++;
      end
   end
   always @(negedge sclk) if (nss === 1'b0) begin
      if (s_bits == 8 || (s_bits > 8 && (s_bits - 8) % REG_W == 0))
         s_out = (s_cmd[7:6] == 2'b00) ? bswap(regs[s_addr]) : '0;
      else
         s_out = s_out << 1;
      miso = s_out[REG_W-1];
   end

   // output monitor, sampled on the falling clk edge
   int n_wrack = 0, n_rd = 0, n_st = 0, n_done = 0, n_err = 0, n_lo = 0;
   int gap_run = 0, gap_min = 1000000;
   bit framed = 0;
   logic [REG_W-1:0] rd_log [0:63];
   always @(negedge clk) begin
      if (bus.wr_ack) n_wrack++;
      if (bus.rd_vld) begin rd_log[n_rd[5:0]] = bus.rd_data; n_rd++; end
      if (bus.status_vld) n_st++;
      if (bus.done) n_done++;
      if (bus.err) n_err++;
      if (nss === 1'b1) gap_run++;
      else begin
         n_lo++;
         if (framed && gap_run > 0 && gap_run < gap_min) gap_min = gap_run;
         gap_run = 0; framed = 1;
      end
   end

   task automatic go(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] nb);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.addr = addr; bus.nbeats = nb;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
      @(negedge clk);
   endtask

   int mb, wa, rb, sb, db, eb, lb;
   task automatic snap();
      mb = mosi_bytes.size(); wa = n_wrack; rb = n_rd; sb = n_st; db = n_done; eb = n_err; lb = n_lo;
   endtask

   initial begin
      bus.start = 1'b0; bus.op = '0; bus.addr = '0; bus.nbeats = '0;
      for (int i = 0; i < 64; i++) regs[i] = '0;
      for (int i = 0; i < 4; i++) wvec[i] = '0;
      regs[3] = 16'h0011; regs[4] = 16'h0022;
      regs[8] = 16'h1357; regs[9] = 16'h2468;

      repeat (3) @(negedge clk);
      chk("rst_nss", nss, 1); chk("rst_sclk", sclk, 0); chk("rst_mosi", mosi, 0);
      chk("rst_busy", bus.busy, 0); chk("rst_rd_data", bus.rd_data, 0); chk("rst_status", bus.status, 0);
      chk("rst_pulses", {bus.done, bus.err, bus.rd_vld, bus.status_vld}, 0);
      @(posedge clk); #1 nrst = 1'b1;

      // single-word write: cmd 0x85, lane 0 then lane 1 of 0xBEEF
      wvec[0] = 16'hBEEF; wbase = wr_idx; snap();
      go(2'b10, 6'h05, 4'd1);
      @(negedge clk); chk("wr1_busy", bus.busy, 1);
      wait_done("wr1");
      chk("wr1_nbytes", mosi_bytes.size() - mb, 3);
      chk("wr1_cmd", mosi_bytes[mb], 8'h85);
      chk("wr1_lane0", mosi_bytes[mb+1], 8'hEF);
      chk("wr1_lane1", mosi_bytes[mb+2], 8'hBE);
      chk("wr1_acks", n_wrack - wa, 1);
      chk("wr1_reg5", regs[5], 16'hBEEF);
      chk("wr1_status", bus.status, 8'h5A);
      chk("wr1_stvld", n_st - sb, 1);
      chk("wr1_no_rdvld", n_rd - rb, 0);
      chk("wr1_busy_end", bus.busy, 0);

      // back-to-back 3-word write crossing the slave's address wrap
      wvec[0] = 16'h1234; wvec[1] = 16'h5678; wvec[2] = 16'h9ABC; wbase = wr_idx; snap();
      go(2'b10, 6'h3E, 4'd3);
      wait_done("wr3");
      chk("wr3_cmd", mosi_bytes[mb], 8'hBE);
      chk("wr3_w0", {mosi_bytes[mb+2], mosi_bytes[mb+1]}, 16'h1234);
      chk("wr3_acks", n_wrack - wa, 3);
      chk("wr3_reg3e", regs[62], 16'h1234);
      chk("wr3_reg3f", regs[63], 16'h5678);
      chk("wr3_reg00", regs[0], 16'h9ABC);
      chk("gap_min", 32'(gap_min >= GAP_CYC), 1);

      // two-word read with status
      snap();
      go(2'b00, 6'h03, 4'd2);
      wait_done("rd2");
      chk("rd2_cmd", mosi_bytes[mb], 8'h03);
      chk("rd2_status", bus.status, 8'h5A);
      chk("rd2_count", n_rd - rb, 2);
      chk("rd2_w0", rd_log[rb[5:0]], 16'h0011);
      chk("rd2_w1", rd_log[6'(rb + 1)], 16'h0022);
      chk("rd2_no_ack", n_wrack - wa, 0);

      // nbeats=0 status poll
      s_status = 8'hC3; snap();
      go(2'b00, 6'h07, 4'd0);
      wait_done("poll");
      chk("poll_nbytes", mosi_bytes.size() - mb, 1);
      chk("poll_status", bus.status, 8'hC3);
      chk("poll_no_rdvld", n_rd - rb, 0);
      chk("poll_stvld", n_st - sb, 1);

      // fast command
      snap();
      go(2'b11, 6'h2A, 4'd5);
`ifdef SPI_REG_MASTER_FASTCMD_EN
      wait_done("fast");
      chk("fast_nbytes", mosi_bytes.size() - mb, 1);
      chk("fast_cmd", mosi_bytes[mb], 8'hEA);
      chk("fast_code", s_fast, 6'h2A);
      chk("fast_no_err", n_err - eb, 0);
`else
      repeat (30) @(negedge clk);
      chk("fast_err", n_err - eb, 1);
      chk("fast_no_frame", n_lo - lb, 0);
      chk("fast_no_done", n_done - db, 0);
      chk("fast_busy", bus.busy, 0);
`endif

      // illegal op in IDLE
      snap();
      go(2'b01, 6'h11, 4'd1);
      repeat (30) @(negedge clk);
      chk("ill_err", n_err - eb, 1);
      chk("ill_no_frame", n_lo - lb, 0);
      chk("ill_busy", bus.busy, 0);

      // start while busy is ignored without err
      s_status = 8'h5A; wvec[0] = 16'hCAFE; wbase = wr_idx; snap();
      go(2'b10, 6'h10, 4'd1);
      repeat (30) @(posedge clk);
      go(2'b00, 6'h3F, 4'd2);
      wait_done("busy");
      repeat (80) @(negedge clk);
      chk("busy_nbytes", mosi_bytes.size() - mb, 3);
      chk("busy_cmd", mosi_bytes[mb], 8'h90);
      chk("busy_reg10", regs[16], 16'hCAFE);
      chk("busy_no_err", n_err - eb, 0);
      chk("busy_one_done", n_done - db, 1);
      chk("busy_no_rdvld", n_rd - rb, 0);

      // async reset in the middle of a read word
      snap();
      go(2'b00, 6'h08, 4'd2);
      begin
         int n = 0;
         while (mosi_bytes.size() < mb + 2 && n < 2000) begin @(negedge clk); n++; end
         chk("mid_reached", 32'(n < 2000), 1);
      end
      #2 nrst = 1'b0;
      #1;
      chk("mid_nss", nss, 1); chk("mid_sclk", sclk, 0); chk("mid_busy", bus.busy, 0);
      repeat (4) @(negedge clk);
      chk("mid_no_rdvld", n_rd - rb, 0);
      @(posedge clk); #1 nrst = 1'b1;
      snap();
      go(2'b00, 6'h08, 4'd2);
      wait_done("post_rst");
      chk("post_count", n_rd - rb, 2);
      chk("post_w0", rd_log[rb[5:0]], 16'h1357);
      chk("post_w1", rd_log[6'(rb + 1)], 16'h2468);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
